conv_frame_scheduler: RTL and testbench
=======================================

// Module: conv_frame_scheduler
// PURPOSE
//  Sequences one frame at a time from the frame memory into the conv line buffer.
//  Latches the frame geometry on start, clears the line buffer, and issues raster-order
//  reads (1-cycle read latency). It forwards each returned pixel as a buffer push,
//  honours a downstream hold, and reports done/error. Sits between the frame RAM and the
//  conv line buffer, ahead of the MAC array.
// PARAMETERS
//  DATA_WIDTH     8     pixel width
//  BUFFER_LENGTH  2000  max frame columns; column fields are $clog2(BUFFER_LENGTH) bits
//  MAX_ROWS       2000  max frame rows; row fields are $clog2(MAX_ROWS) bits
//  ADDR_WIDTH     22    frame-memory address width
//  KERNEL_SIZE    3     kernel rows = kernel columns; minimum legal rows/cols
// PORTS
//  clk           in   1        clock, all logic on rising edge
//  rst           in   1        synchronous reset, active-high
//  start         in   1        1-cycle request; sampled only in IDLE
//  cfg_cols      in   CW       frame columns (CW = $clog2(BUFFER_LENGTH))
//  cfg_rows      in   RW       frame rows (RW = $clog2(MAX_ROWS))
//  cfg_base      in   ADDR_W   frame start address in frame memory
//  hold          in   1        downstream stall; no new read is issued while high
//  mem_rd_en     out  1        frame-memory read strobe
//  mem_addr      out  ADDR_W   frame-memory read address
//  mem_rd_data   in   DW       read data, valid the cycle after mem_rd_en
//  buf_clear     out  1        line-buffer clear (drives buffer reset through inverter)
//  buf_valid_in  out  1        pixel push to line buffer
//  buf_in_point  out  DW       pixel to line buffer
//  buf_col_size  out  CW       latched cfg_cols, held stable for the whole frame
//  busy          out  1        high from accepted start until done
//  done          out  1        1-cycle pulse after last pixel pushed
//  cfg_err       out  1        1-cycle pulse: start rejected, bad geometry
// BEHAVIOUR
//  Reset: all outputs 0; mem_addr and buf_col_size 0; FSM goes to IDLE; counters 0.
//    Reset mid-frame aborts at once; no done pulse.
//  States:
//    IDLE: on start, check geometry.
//      If cfg_cols<KERNEL_SIZE, cfg_rows<KERNEL_SIZE, or cfg_cols>BUFFER_LENGTH:
//      pulse cfg_err, stay in IDLE.
//      Otherwise latch cols/rows/base, go to CLEAR.
//    CLEAR: buf_clear=1 for exactly 1 cycle; col_cnt=row_cnt=0, addr=base; go to STREAM.
//    STREAM: each cycle with hold=0, assert mem_rd_en with mem_addr=addr, then addr++.
//      col_cnt wraps at cols-1 and increments row_cnt.
//      After the read with col=cols-1 and row=rows-1, go to FLUSH.
//      With hold=1: mem_rd_en=0, counters frozen.
//    FLUSH: 1 cycle, lets the last read return; go to DONE.
//    DONE: pulse done for 1 cycle; go to IDLE.
//  Push path: buf_valid_in = mem_rd_en delayed 1 cycle; buf_in_point = mem_rd_data.
//    An in-flight read is always pushed, even if hold rises (the line buffer never stalls).
//  Read count per frame = cols*rows exactly.
//    First mem_rd_en occurs 2 cycles after start (IDLE->CLEAR->STREAM).
//    done occurs 2 cycles after the last mem_rd_en when no hold.
//  busy = state != IDLE. start while busy is ignored, with no error.
//  Address math is modulo 2^ADDR_WIDTH; base+cols*rows wrapping is legal and silent.
//  cols = BUFFER_LENGTH is legal; col_cnt must not overflow CW bits.
//  buf_col_size changes only in IDLE on an accepted start.
// TESTING
//  1. cols=4, rows=3, base=0x100, hold=0:
//     12 reads, addr 0x100..0x10B consecutive; buf_clear 1 cycle before first read;
//     done 2 cycles after last read; busy high throughout.
//  2. Same frame, hold=1 for 3 cycles mid-row 1:
//     read issued before hold is still pushed; no reads during hold;
//     total pushes=12, in order.
//  3. start with cols=2 or rows=2 -> cfg_err pulse, busy stays 0, no mem_rd_en.
//  4. Second start while busy (cols=5) -> ignored; buf_col_size stays 4; cfg_err=0.
//  5. Reset asserted after 5 reads -> next cycle all outputs 0 and IDLE;
//     new start runs a full clean frame.
//  6. cols=3, rows=3, base=2^ADDR_WIDTH-4 -> addresses wrap to 0..4; 9 pushes; done.

Source files
------------

// File: rtl/conv_frame_scheduler.sv
// Streams one frame from frame RAM into the conv line buffer: clear, raster reads, push, done/cfg_err pulses.
// First read 2 cycles after start, push 1 cycle after each read; hold gates new reads only, in-flight reads always push.
module conv_frame_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int BUFFER_LENGTH = 2000,
  parameter int MAX_ROWS      = 2000,
  parameter int ADDR_WIDTH    = 22,
  parameter int KERNEL_SIZE   = 3,
  localparam int CW = $clog2(BUFFER_LENGTH),
  localparam int RW = $clog2(MAX_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         cfg_cols,
  input  logic [RW-1:0]         cfg_rows,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  buf_clear,
  output logic                  buf_valid_in,
  output logic [DATA_WIDTH-1:0] buf_in_point,
  output logic [CW-1:0]         buf_col_size,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [31:0] LP_KSIZE = 32'(KERNEL_SIZE);
  localparam logic [31:0] LP_BLEN  = 32'(BUFFER_LENGTH);

  state_t                r_state;
  logic [CW-1:0]         r_cols;
  logic [CW-1:0]         r_col_cnt;
  logic [RW-1:0]         r_rows;
  logic [RW-1:0]         r_row_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_buf_clear;
  logic                  r_done;
  logic                  r_cfg_err;
  logic                  r_push;

  logic w_rd;
  logic w_geom_bad;
  logic w_last_col;
  logic w_last_row;

  // Compare in 32 bits so a BUFFER_LENGTH that does not fit CW still works.
  assign w_geom_bad = (32'(cfg_cols) < LP_KSIZE) || (32'(cfg_rows) < LP_KSIZE) ||
                      (32'(cfg_cols) > LP_BLEN);
  assign w_rd       = (r_state == S_STREAM) && !hold;
  assign w_last_col = (r_col_cnt == r_cols - CW'(1));
  assign w_last_row = (r_row_cnt == r_rows - RW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cols      <= '0;
      r_rows      <= '0;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_addr      <= '0;
      r_buf_clear <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_push      <= 1'b0;
    end else begin
      r_buf_clear <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_push      <= w_rd;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_geom_bad) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_cols      <= cfg_cols;
              r_rows      <= cfg_rows;
              r_addr      <= cfg_base;
              r_buf_clear <= 1'b1;
              r_state     <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          r_col_cnt <= '0;
          r_row_cnt <= '0;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_rd) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_last_col) begin
              r_col_cnt <= '0;
              if (w_last_row) begin
                r_state <= S_FLUSH;
              end else begin
                r_row_cnt <= r_row_cnt + RW'(1);
              end
            end else begin
              r_col_cnt <= r_col_cnt + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en    = w_rd;
  assign mem_addr     = r_addr;
  assign buf_clear    = r_buf_clear;
  assign buf_valid_in = r_push;
  assign buf_in_point = r_push ? mem_rd_data : '0;
  assign buf_col_size = r_cols;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Bench for conv_frame_scheduler: frame-level reference model fills read/pixel queues at start,
// a negedge monitor pops and compares whenever the DUT reads, pushes, clears, errors or finishes.
module tb_conv_frame_scheduler;
  localparam int AW = 22;
  localparam int DW = 8;
  localparam int CW = 11;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [CW-1:0] cfg_cols = '0;
  logic [RW-1:0] cfg_rows = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          buf_clear;
  logic          buf_valid_in;
  logic [DW-1:0] buf_in_point;
  logic [CW-1:0] buf_col_size;
  logic          busy;
  logic          done;
  logic          cfg_err;

  always #5 clk = ~clk;

  conv_frame_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_cols     (cfg_cols),
    .cfg_rows     (cfg_rows),
    .cfg_base     (cfg_base),
    .hold         (hold),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .buf_clear    (buf_clear),
    .buf_valid_in (buf_valid_in),
    .buf_in_point (buf_in_point),
    .buf_col_size (buf_col_size),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  // Frame RAM with one cycle of read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pix(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_pix[$];
  int            clr_exp = -1, err_exp = -1, done_exp = -1, first_exp = -1;
  bit            fr_active = 1'b0, acc_pending = 1'b0, prev_rd = 1'b0;
  int            acc_cyc = 0, rd_in_frame = 0, done_seen = 0;
  logic [CW-1:0] pend_cols = '0, cur_cols = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
      exp_addr.delete();
      exp_pix.delete();
      fr_active = 1'b0; acc_pending = 1'b0; cur_cols = '0;
      clr_exp = -1; err_exp = -1; done_exp = -1; first_exp = -1;
    end else begin
      if (acc_pending && cyc == acc_cyc + 1) begin
        fr_active = 1'b1; acc_pending = 1'b0; cur_cols = pend_cols;
      end
      chk("busy", busy, fr_active);
      chk("col_size", buf_col_size, cur_cols);
      if (buf_clear || cyc == clr_exp) chk("buf_clear", buf_clear, cyc == clr_exp);
      if (cfg_err || cyc == err_exp) chk("cfg_err", cfg_err, cyc == err_exp);
      if (hold) chk("rd_during_hold", mem_rd_en, 0);
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) chk("spurious_rd", mem_rd_en, 0);
        else begin
          chk("rd_addr", mem_addr, exp_addr.pop_front());
          if (exp_addr.size() == 0) done_exp = cyc + 2;
        end
        if (first_exp >= 0) begin
          chk("first_rd_cyc", cyc, first_exp);
          first_exp = -1;
        end
        rd_in_frame++;
      end
      if (buf_valid_in || prev_rd) chk("push_lat", buf_valid_in, prev_rd);
      if (buf_valid_in) begin
        if (exp_pix.size() == 0) chk("spurious_push", buf_valid_in, 0);
        else chk("pix", buf_in_point, exp_pix.pop_front());
      end
      if (done || cyc == done_exp) begin
        chk("done", done, cyc == done_exp);
        done_exp = -1;
        if (done) begin
          chk("pix_left", exp_pix.size(), 0);
          done_seen++;
          fr_active = 1'b0;
        end
      end
      prev_rd = mem_rd_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int c, input int r, input logic [AW-1:0] b);
    logic [AW-1:0] a;
    cfg_cols = CW'(c);
    cfg_rows = RW'(r);
    cfg_base = b;
    start    = 1'b1;
    if (fr_active || acc_pending) begin
      // busy: request must be silently dropped
    end else if (c < 3 || r < 3 || c > 2000) begin
      err_exp = cyc + 1;
    end else begin
      for (int i = 0; i < c * r; i++) begin
        a = b + AW'(i);
        exp_addr.push_back(a);
        exp_pix.push_back(pix(a));
      end
      clr_exp = cyc + 1; first_exp = cyc + 2;
      acc_pending = 1'b1; acc_cyc = cyc; pend_cols = CW'(c); rd_in_frame = 0;
    end
  endtask

  // hmode: 0 none, 1 random hold, 2 three-cycle hold once six reads are out
  task automatic run_frame(input int c, input int r, input logic [AW-1:0] b,
                           input int hmode, input int spur);
    int d0, n, hc;
    bit spd;
    d0 = done_seen; n = 0; hc = 3; spd = 1'b0;
    do_start(c, r, b);
    step();
    start = 1'b0;
    while (done_seen == d0 && n < 20000) begin
      hold = 1'b0;
      if (hmode == 1 && rd_in_frame > 0 && rd_in_frame < c * r) hold = ($urandom_range(0, 2) == 0);
      if (hmode == 2 && rd_in_frame == 6 && hc > 0) begin
        hold = 1'b1; hc--;
      end
      if (spur > 0 && rd_in_frame >= spur && !spd) begin
        spd = 1'b1;
        do_start(5, r, b + AW'(100));
      end else start = 1'b0;
      step();
      n++;
    end
    hold = 1'b0; start = 1'b0;
    chk("frame_done", done_seen, d0 + 1);
    step();
  endtask

  task automatic bad_start(input int c, input int r);
    do_start(c, r, '0);
    step();
    start = 1'b0;
    repeat (3) step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_clear"}, buf_clear, 0);
    chk({tag, "_valid"}, buf_valid_in, 0);
    chk({tag, "_point"}, buf_in_point, 0);
    chk({tag, "_colsz"}, buf_col_size, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk_idle("rst");
    step();
    rst = 1'b0;
    step();

    run_frame(4, 3, AW'('h100), 0, 0);
    run_frame(4, 3, AW'('h100), 2, 0);
    bad_start(2, 5);
    bad_start(5, 2);
    bad_start(2001, 4);
    run_frame(4, 3, AW'('h300), 0, 3);

    // abort mid-frame after five reads
    do_start(4, 3, AW'('h200));
    step();
    start = 1'b0;
    n = 0;
    while (rd_in_frame < 5 && n < 100) begin
      step();
      n++;
    end
    chk("reads_before_abort", rd_in_frame, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    step();
    run_frame(4, 3, AW'('h100), 0, 0);

    run_frame(3, 3, AW'(22'h3FFFFC), 0, 0);
    for (int k = 0; k < 8; k++) begin
      run_frame(int'($urandom_range(3, 9)), int'($urandom_range(3, 6)), AW'($urandom),
                int'($urandom_range(0, 1)), 0);
    end
    run_frame(2000, 3, AW'($urandom), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
